mem_arbiter: RTL

- Sits between the I-cache miss handler, the D-cache miss/write-through handler and the single shared main memory.
- Grants the memory to one requester at a time and sequences 8-word block fills as pipelined read bursts.
- Issues single-cycle write-through stores.
- Routes returning read data, with a word index, to the cache that owns the current fill.

---
 rtl/mem_arbiter.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shared main-memory arbiter for the I-cache and D-cache.
//                Grants one requester at a time (D write-through first, then
//                D fill, then I fill), sequences block fills as pipelined
//                read bursts and steers returning words to the owning cache.
//                Optional build macro ARB_PERF_CNT_EN adds saturating
//                performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_miss_req,
    input  logic [ADDR_W-1:0]                  i_miss_addr,
    input  logic                               d_miss_req,
    input  logic [ADDR_W-1:0]                  d_miss_addr,
    input  logic                               d_wr_req,
    input  logic [ADDR_W-1:0]                  d_wr_addr,
    input  logic [DATA_W-1:0]                  d_wr_data,
    input  logic [DATA_W-1:0]                  mem_data_out,
    input  logic                               mem_data_valid,
    output logic                               mem_enable,
    output logic                               mem_wr,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                  mem_data_in,
    output logic                               i_fill_valid,
    output logic                               d_fill_valid,
    output logic [DATA_W-1:0]                  fill_data,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
    output logic                               i_fill_done,
    output logic                               d_fill_done,
    output logic                               d_wr_ack,
`ifdef ARB_PERF_CNT_EN
    output logic [15:0]                        perf_i_fills,
    output logic [15:0]                        perf_d_fills,
    output logic [15:0]                        perf_writes,
    output logic [15:0]                        perf_conflict_cycles,
`endif
    output logic                               busy
);

    // Word index width and counter width (one extra bit so the issue
    // counter can reach WORDS_PER_BLOCK and stop).
    localparam int c_WORD_W = $clog2(WORDS_PER_BLOCK);
    localparam int c_CNT_W  = c_WORD_W + 1;
    localparam logic [c_CNT_W-1:0] c_WPB  = c_CNT_W'(WORDS_PER_BLOCK);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_owner;      // 0 = I-cache, 1 = D-cache
    logic [c_CNT_W-1:0]  r_issueCnt;
    logic [c_CNT_W-1:0]  r_recvCnt;
    logic                w_issuing;
    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   w_offset;

    // Block base is the latched address with the word-in-block and byte bits cleared.
    assign w_base    = {r_addr[ADDR_W-1:c_CNT_W], {c_CNT_W{1'b0}}};
    assign w_offset  = ADDR_W'({r_issueCnt, 1'b0});
    assign w_issuing = (r_issueCnt < c_WPB);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Grant latching in IDLE and issue/receive counting during a fill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_data     <= '0;
            r_owner    <= 1'b0;
            r_issueCnt <= '0;
            r_recvCnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_issueCnt <= '0;
                    r_recvCnt  <= '0;
                    if (d_wr_req) begin
                        r_addr  <= d_wr_addr;
                        r_data  <= d_wr_data;
                        r_owner <= 1'b1;
                    end else if (d_miss_req) begin
                        r_addr  <= d_miss_addr;
                        r_owner <= 1'b1;
                    end else if (i_miss_req) begin
                        r_addr  <= i_miss_addr;
                        r_owner <= 1'b0;
                    end
                end
                FILL: begin
                    if (w_issuing) begin
                        r_issueCnt <= r_issueCnt + 1'b1;
                    end
                    if (mem_data_valid) begin
                        r_recvCnt <= r_recvCnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode; everything is forced to zero while in reset.
    always_comb begin
        w_nextState  = r_state;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        fill_data    = '0;
        fill_word    = '0;
        i_fill_done  = 1'b0;
        d_fill_done  = 1'b0;
        d_wr_ack     = 1'b0;
        busy         = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                if (d_wr_req) begin
                    w_nextState = WRITE;
                end else if (d_miss_req || i_miss_req) begin
                    w_nextState = FILL;
                end
            end
            WRITE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = r_addr;
                mem_data_in = r_data;
                d_wr_ack    = 1'b1;
                w_nextState = IDLE;
            end
            FILL: begin
                if (w_issuing) begin
                    mem_enable = 1'b1;
                    mem_addr   = w_base + w_offset;
                end
                if (mem_data_valid) begin
                    fill_data    = mem_data_out;
                    fill_word    = r_recvCnt[c_WORD_W-1:0];
                    i_fill_valid = !r_owner;
                    d_fill_valid = r_owner;
                    if (r_recvCnt == c_LAST) begin
                        i_fill_done = !r_owner;
                        d_fill_done = r_owner;
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        if (!rst_n) begin
            mem_enable   = 1'b0;
            mem_wr       = 1'b0;
            mem_addr     = '0;
            mem_data_in  = '0;
            i_fill_valid = 1'b0;
            d_fill_valid = 1'b0;
            fill_data    = '0;
            fill_word    = '0;
            i_fill_done  = 1'b0;
            d_fill_done  = 1'b0;
            d_wr_ack     = 1'b0;
            busy         = 1'b0;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic        w_conflict;
    logic [15:0] r_perfIFills;
    logic [15:0] r_perfDFills;
    logic [15:0] r_perfWrites;
    logic [15:0] r_perfConflict;

    // A request is in conflict when asserted but neither granted nor being served this cycle.
    always_comb begin
        w_conflict = 1'b0;
        case (r_state)
            IDLE:    w_conflict = d_wr_req ? (d_miss_req | i_miss_req) : (d_miss_req & i_miss_req);
            WRITE:   w_conflict = d_miss_req | i_miss_req;
            FILL:    w_conflict = r_owner ? (d_wr_req | i_miss_req) : (d_wr_req | d_miss_req);
            default: w_conflict = 1'b0;
        endcase
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perfIFills   <= '0;
            r_perfDFills   <= '0;
            r_perfWrites   <= '0;
            r_perfConflict <= '0;
        end else begin
            if (i_fill_done && (r_perfIFills != 16'hFFFF)) begin
                r_perfIFills <= r_perfIFills + 16'd1;
            end
            if (d_fill_done && (r_perfDFills != 16'hFFFF)) begin
                r_perfDFills <= r_perfDFills + 16'd1;
            end
            if (d_wr_ack && (r_perfWrites != 16'hFFFF)) begin
                r_perfWrites <= r_perfWrites + 16'd1;
            end
            if (w_conflict && (r_perfConflict != 16'hFFFF)) begin
                r_perfConflict <= r_perfConflict + 16'd1;
            end
        end
    end

    assign perf_i_fills         = rst_n ? r_perfIFills   : 16'h0000;
    assign perf_d_fills         = rst_n ? r_perfDFills   : 16'h0000;
    assign perf_writes          = rst_n ? r_perfWrites   : 16'h0000;
    assign perf_conflict_cycles = rst_n ? r_perfConflict : 16'h0000;
`endif

endmodule

`default_nettype wire
